// File: rtl/axil_regbank_pkg.sv
// -----------------------------------------------------------------------------
// axil_regbank_pkg
// Shared definitions for the AXI4-Lite register bank:
//   - AXI response codes
//   - write / read FSM state encodings
//   - address decode result type
// Optional feature macro: AXIL_REGBANK_ERR_RESP_EN (SLVERR/DECERR responses).
// -----------------------------------------------------------------------------
package axil_regbank_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Wide enough for NUM_RW + NUM_RO up to 128 words.
    localparam int unsigned IDX_BITS = 7;

    typedef enum logic [1:0] {
        W_IDLE,
        W_EXEC,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    typedef enum logic [1:0] {
        HIT_RW,
        HIT_RO,
        MISS
    } hit_t;

`ifdef AXIL_REGBANK_ERR_RESP_EN
    // RO registers are readable but refuse writes; unmapped is always DECERR.
    function automatic logic [1:0] resp_for(input hit_t hit, input logic is_write);
        case (hit)
            HIT_RW:  return RESP_OKAY;
            HIT_RO:  return is_write ? RESP_SLVERR : RESP_OKAY;
            default: return RESP_DECERR;
        endcase
    endfunction
`endif

endpackage

// File: rtl/axil_regbank_decode.sv
// -----------------------------------------------------------------------------
// axil_regbank_decode
// Combinational address decoder: byte address -> {hit type, register index}.
//   addr : byte address from AW or AR channel
//   hit  : HIT_RW / HIT_RO / MISS
//   idx  : RW index (HIT_RW) or RO index (HIT_RO), 0 on MISS
// Low address bits below the word size are ignored.
// -----------------------------------------------------------------------------
module axil_regbank_decode
    import axil_regbank_pkg::*;
#(
    parameter int                   ADDR_BITS = 32,
    parameter int                   DATA_BITS = 32,
    parameter int                   NUM_RW    = 4,
    parameter int                   NUM_RO    = 8,
    parameter logic [ADDR_BITS-1:0] BASE_ADDR = 'h40
) (
    input  logic [ADDR_BITS-1:0] addr,
    output hit_t                 hit,
    output logic [IDX_BITS-1:0]  idx
);

    localparam int unsigned SHIFT = $clog2(DATA_BITS / 8);

    logic [ADDR_BITS-1:0] word;

    always_comb begin
        word = (addr - BASE_ADDR) >> SHIFT;
        hit  = MISS;
        idx  = '0;
        if (addr >= BASE_ADDR) begin
            if (word < ADDR_BITS'(NUM_RW)) begin
                hit = HIT_RW;
                idx = word[IDX_BITS-1:0];
            end else if (word < ADDR_BITS'(NUM_RW + NUM_RO)) begin
                hit = HIT_RO;
                idx = word[IDX_BITS-1:0] - IDX_BITS'(NUM_RW);
            end
        end
    end

endmodule

// File: rtl/axi_lite_regbank.sv
// -----------------------------------------------------------------------------
// axi_lite_regbank
// AXI4-Lite slave with NUM_RW control registers and NUM_RO status registers
// starting at BASE_ADDR. Single outstanding write and single outstanding read;
// the two channels run independently.
// Ports:
//   s_axi_aclk / s_axi_aresetn : clock, synchronous active-low reset
//   s_axi_aw* / s_axi_w* / s_axi_b* : AXI4-Lite write address/data/response
//   s_axi_ar* / s_axi_r*            : AXI4-Lite read address/data
//   rw_q        : flat control register contents, reg i at [i*DATA_BITS +: DATA_BITS]
//   rw_wr_pulse : bit i high for one cycle after reg i is written
//   ro_d        : flat status inputs, same packing as rw_q
//   ro_rd_pulse : bit i high in the cycle the R handshake returns status reg i
// Optional feature macro: AXIL_REGBANK_ERR_RESP_EN
//   defined   -> SLVERR on RO writes, DECERR on unmapped accesses
//   undefined -> all responses OKAY (illegal writes still dropped)
// -----------------------------------------------------------------------------
module axi_lite_regbank
    import axil_regbank_pkg::*;
#(
    parameter int                   ADDR_BITS = 32,
    parameter int                   DATA_BITS = 32,
    parameter int                   NUM_RW    = 4,
    parameter int                   NUM_RO    = 8,
    parameter logic [ADDR_BITS-1:0] BASE_ADDR = 'h40
) (
    input  logic                          s_axi_aclk,
    input  logic                          s_axi_aresetn,
    input  logic [ADDR_BITS-1:0]          s_axi_awaddr,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [DATA_BITS-1:0]          s_axi_wdata,
    input  logic [DATA_BITS/8-1:0]        s_axi_wstrb,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [ADDR_BITS-1:0]          s_axi_araddr,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [DATA_BITS-1:0]          s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    output logic [NUM_RW*DATA_BITS-1:0]   rw_q,
    output logic [NUM_RW-1:0]             rw_wr_pulse,
    // NUM_RO = 0 keeps a one-word dummy status port so widths stay legal.
    input  logic [(NUM_RO > 0 ? NUM_RO : 1)*DATA_BITS-1:0] ro_d,
    output logic [(NUM_RO > 0 ? NUM_RO : 1)-1:0]           ro_rd_pulse
);

    localparam int unsigned DATA_BYTES = DATA_BITS / 8;

    // ---------------- write side ----------------
    w_state_t               w_state, w_next;
    logic                   aw_done, w_done;
    logic [ADDR_BITS-1:0]   awaddr_q;
    logic [DATA_BITS-1:0]   wdata_q;
    logic [DATA_BYTES-1:0]  wstrb_q;
    logic [DATA_BITS-1:0]   rw_reg [NUM_RW];
    hit_t                   w_hit;
    logic [IDX_BITS-1:0]    w_idx;
    logic                   aw_hs, w_hs;

    // ---------------- read side -----------------
    r_state_t               r_state, r_next;
    hit_t                   r_hit, r_hit_q;
    logic [IDX_BITS-1:0]    r_idx, r_idx_q;
    logic [DATA_BITS-1:0]   rd_mux;
    logic                   ar_hs, r_hs;

    axil_regbank_decode #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS),
        .NUM_RW    (NUM_RW),
        .NUM_RO    (NUM_RO),
        .BASE_ADDR (BASE_ADDR)
    ) u_wdec (
        .addr (awaddr_q),
        .hit  (w_hit),
        .idx  (w_idx)
    );

    axil_regbank_decode #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS),
        .NUM_RW    (NUM_RW),
        .NUM_RO    (NUM_RO),
        .BASE_ADDR (BASE_ADDR)
    ) u_rdec (
        .addr (s_axi_araddr),
        .hit  (r_hit),
        .idx  (r_idx)
    );

    assign s_axi_awready = (w_state == W_IDLE) && !aw_done;
    assign s_axi_wready  = (w_state == W_IDLE) && !w_done;
    assign s_axi_bvalid  = (w_state == W_RESP);
    assign s_axi_arready = (r_state == R_IDLE);
    assign s_axi_rvalid  = (r_state == R_DATA);

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid  && s_axi_wready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign r_hs  = s_axi_rvalid  && s_axi_rready;

    for (genvar gi = 0; gi < NUM_RW; gi++) begin : g_flat
        assign rw_q[gi*DATA_BITS +: DATA_BITS] = rw_reg[gi];
    end

    // ---------------- write FSM ----------------
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if ((aw_done || aw_hs) && (w_done || w_hs)) w_next = W_EXEC;
            W_EXEC:  w_next = W_RESP;
            W_RESP:  if (s_axi_bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            w_state     <= W_IDLE;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            s_axi_bresp <= RESP_OKAY;
            rw_wr_pulse <= '0;
            for (int unsigned i = 0; i < NUM_RW; i++) rw_reg[i] <= '0;
        end else begin
            w_state     <= w_next;
            rw_wr_pulse <= '0;
            if (aw_hs) begin
                awaddr_q <= s_axi_awaddr;
                aw_done  <= 1'b1;
            end
            if (w_hs) begin
                wdata_q <= s_axi_wdata;
                wstrb_q <= s_axi_wstrb;
                w_done  <= 1'b1;
            end
            if (w_state == W_EXEC) begin
                // Flags can clear here: readies stay low until W_IDLE anyway.
                aw_done <= 1'b0;
                w_done  <= 1'b0;
`ifdef AXIL_REGBANK_ERR_RESP_EN
                s_axi_bresp <= resp_for(w_hit, 1'b1);
`else
                s_axi_bresp <= RESP_OKAY;
`endif
                for (int unsigned i = 0; i < NUM_RW; i++) begin
                    if (w_hit == HIT_RW && w_idx == IDX_BITS'(i)) begin
                        rw_wr_pulse[i] <= 1'b1;
                        for (int unsigned b = 0; b < DATA_BYTES; b++) begin
                            if (wstrb_q[b]) rw_reg[i][b*8 +: 8] <= wdata_q[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // ---------------- read FSM -----------------
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (s_axi_arvalid) r_next = R_DATA;
            R_DATA:  if (s_axi_rready)  r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Reads see rw_reg before any same-edge W_EXEC update.
    always_comb begin
        rd_mux = '0;
        for (int unsigned i = 0; i < NUM_RW; i++) begin
            if (r_hit == HIT_RW && r_idx == IDX_BITS'(i)) rd_mux = rw_reg[i];
        end
        for (int unsigned i = 0; i < NUM_RO; i++) begin
            if (r_hit == HIT_RO && r_idx == IDX_BITS'(i)) rd_mux = ro_d[i*DATA_BITS +: DATA_BITS];
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            r_state     <= R_IDLE;
            r_hit_q     <= MISS;
            r_idx_q     <= '0;
            s_axi_rdata <= '0;
            s_axi_rresp <= RESP_OKAY;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                r_hit_q     <= r_hit;
                r_idx_q     <= r_idx;
                s_axi_rdata <= rd_mux;
`ifdef AXIL_REGBANK_ERR_RESP_EN
                s_axi_rresp <= resp_for(r_hit, 1'b0);
`else
                s_axi_rresp <= RESP_OKAY;
`endif
            end
        end
    end

    always_comb begin
        ro_rd_pulse = '0;
        for (int unsigned i = 0; i < NUM_RO; i++) begin
            if (r_hs && r_hit_q == HIT_RO && r_idx_q == IDX_BITS'(i)) ro_rd_pulse[i] = 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_lite_regbank.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_regbank
// Directed and randomized checks of axi_lite_regbank against a word-array
// model of the register map. Honours AXIL_REGBANK_ERR_RESP_EN for responses.
// -----------------------------------------------------------------------------
module tb_axi_lite_regbank;

    localparam int          AW   = 32;
    localparam int          DW   = 32;
    localparam int          NRW  = 4;
    localparam int          NRO  = 8;
    localparam logic [31:0] BASE = 32'h40;

    logic              clk = 1'b0;
    logic              aresetn;
    logic [AW-1:0]     awaddr;
    logic              awvalid;
    logic              awready;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [AW-1:0]     araddr;
    logic              arvalid;
    logic              arready;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [NRW*DW-1:0] rw_q;
    logic [NRW-1:0]    rw_wr_pulse;
    logic [NRO*DW-1:0] ro_d;
    logic [NRO-1:0]    ro_rd_pulse;

    always #5 clk = ~clk;

    axi_lite_regbank #(
        .ADDR_BITS (AW),
        .DATA_BITS (DW),
        .NUM_RW    (NRW),
        .NUM_RO    (NRO),
        .BASE_ADDR (BASE)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (aresetn),
        .s_axi_awaddr  (awaddr),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .rw_q          (rw_q),
        .rw_wr_pulse   (rw_wr_pulse),
        .ro_d          (ro_d),
        .ro_rd_pulse   (ro_rd_pulse)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] rw_m [NRW];
    logic [31:0] ro_m [NRO];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rw_flat();
        logic [127:0] f;
        f = '0;
        for (int i = 0; i < NRW; i++) f[i*32 +: 32] = rw_m[i];
        return f;
    endfunction

    task automatic drive_ro();
        for (int i = 0; i < NRO; i++) ro_d[i*32 +: 32] = ro_m[i];
    endtask

    task automatic randomize_ro();
        for (int i = 0; i < NRO; i++) ro_m[i] = $urandom;
        drive_ro();
    endtask

    // 0 = RW, 1 = RO, 2 = unmapped
    function automatic int kind_of(input logic [31:0] a, output int idx);
        idx = 0;
        if (a < BASE) return 2;
        idx = int'((a - BASE) >> 2);
        if (idx < NRW) return 0;
        if (idx < NRW + NRO) begin
            idx = idx - NRW;
            return 1;
        end
        idx = 0;
        return 2;
    endfunction

    function automatic logic [1:0] exp_resp(input int kind, input bit is_write);
`ifdef AXIL_REGBANK_ERR_RESP_EN
        if (kind == 0) return 2'b00;
        if (kind == 1) return is_write ? 2'b10 : 2'b00;
        return 2'b11;
`else
        return 2'b00;
`endif
    endfunction

    task automatic model_write(input int kind, input int idx, input logic [31:0] d,
                               input logic [3:0] s, output logic [3:0] pulse);
        pulse = '0;
        if (kind == 0) begin
            for (int b = 0; b < 4; b++) if (s[b]) rw_m[idx][b*8 +: 8] = d[b*8 +: 8];
            pulse[idx] = 1'b1;
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int k, idx;
        logic [3:0] pexp;
        k = kind_of(a, idx);
        awaddr = a; awvalid = 1'b1;
        wdata = d; wstrb = s; wvalid = 1'b1;
        check("wr_ready_idle", {awready, wready}, 2'b11);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        check("wr_exec_bvalid", bvalid, 1'b0);
        check("wr_exec_pulse", rw_wr_pulse, 4'b0);
        model_write(k, idx, d, s, pexp);
        step();
        check("wr_bvalid", bvalid, 1'b1);
        check("wr_bresp", bresp, exp_resp(k, 1'b1));
        check("wr_pulse", rw_wr_pulse, pexp);
        check("wr_rw_q", rw_q, rw_flat());
        bready = 1'b1;
        step();
        bready = 1'b0;
        check("wr_after_b", {bvalid, awready, wready}, 3'b011);
        check("wr_pulse_clear", rw_wr_pulse, 4'b0);
    endtask

    task automatic do_read(input logic [31:0] a, input int hold);
        int k, idx;
        logic [31:0] dexp;
        logic [7:0] pexp;
        k = kind_of(a, idx);
        dexp = (k == 0) ? rw_m[idx] : (k == 1) ? ro_m[idx] : 32'h0;
        pexp = (k == 1) ? 8'(1 << idx) : 8'h0;
        araddr = a; arvalid = 1'b1;
        check("rd_arready", arready, 1'b1);
        step();
        arvalid = 1'b0;
        // Status inputs change after sampling; the reply must not.
        randomize_ro();
        check("rd_rvalid", rvalid, 1'b1);
        check("rd_rdata", rdata, dexp);
        check("rd_rresp", rresp, exp_resp(k, 1'b0));
        for (int h = 0; h < hold; h++) begin
            check("rd_hold_pulse", ro_rd_pulse, 8'h0);
            step();
            check("rd_hold_rdata", {rvalid, rdata}, {1'b1, dexp});
        end
        rready = 1'b1;
        #1;
        check("rd_ro_pulse", ro_rd_pulse, pexp);
        step();
        rready = 1'b0;
        #1;
        check("rd_done", {rvalid, arready}, 2'b01);
        check("rd_pulse_clear", ro_rd_pulse, 8'h0);
    endtask

    initial begin : main
        logic [31:0] old0, d, a;
        logic [3:0]  pexp;
        int          k, idx;

        aresetn = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        for (int i = 0; i < NRW; i++) rw_m[i] = '0;
        for (int i = 0; i < NRO; i++) ro_m[i] = '0;
        drive_ro();

        // Reset state
        repeat (3) step();
        check("rst_readies", {awready, wready, arready}, 3'b111);
        check("rst_valids", {bvalid, rvalid}, 2'b00);
        check("rst_resps", {bresp, rresp}, 4'b0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_rw_q", rw_q, 128'h0);
        check("rst_pulses", {rw_wr_pulse, ro_rd_pulse}, 12'h0);
        aresetn = 1'b1;
        step();

        do_read(BASE + 32'h0, 0);

        // Partial-strobe write
        do_write(BASE + 32'h4, 32'hA5A5_1234, 4'b0101);
        check("strb_const", rw_q[63:32], 32'h00A5_0034);

        // W three cycles ahead of AW, slow bready
        d = $urandom;
        wdata = d; wstrb = 4'hF; wvalid = 1'b1;
        check("split_wready", wready, 1'b1);
        step();
        wvalid = 1'b0;
        check("split_w_taken", {awready, wready}, 2'b10);
        step();
        step();
        awaddr = BASE + 32'h8; awvalid = 1'b1;
        check("split_awready", awready, 1'b1);
        step();
        awvalid = 1'b0;
        check("split_exec_bvalid", bvalid, 1'b0);
        rw_m[2] = d;
        step();
        check("split_pulse", rw_wr_pulse, 4'b0100);
        check("split_rw_q", rw_q, rw_flat());
        for (int i = 0; i < 5; i++) begin
            check("split_bvalid_hold", {bvalid, awready, wready}, 3'b100);
            step();
            check("split_pulse_once", rw_wr_pulse, 4'b0);
        end
        check("split_bresp", bresp, 2'b00);
        bready = 1'b1;
        step();
        bready = 1'b0;
        check("split_done", {bvalid, awready, wready}, 3'b011);
        check("split_rw_q_final", rw_q, rw_flat());

        // Status read
        ro_m[2] = 32'hDEAD_BEEF;
        drive_ro();
        do_read(BASE + 32'h18, 2);

        // Error paths
        do_write(BASE + 32'h10, 32'h1357_9BDF, 4'hF);
        do_read(BASE + 32'h100, 1);
        do_read(BASE - 32'h4, 0);

        // Read accepted during W_EXEC of the same register sees old value
        old0 = rw_m[0];
        d = $urandom;
        awaddr = BASE; awvalid = 1'b1; wdata = d; wstrb = 4'hF; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = BASE; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        rw_m[0] = d;
        check("raw_rdata_old", rdata, old0);
        check("raw_rw_q_new", rw_q, rw_flat());
        check("raw_both_valid", {bvalid, rvalid}, 2'b11);
        bready = 1'b1; rready = 1'b1;
        step();
        bready = 1'b0; rready = 1'b0;
        #1;
        check("raw_idle", {awready, wready, arready, bvalid, rvalid}, 5'b11100);

        // Randomized traffic
        for (int n = 0; n < 48; n++) begin
            randomize_ro();
            idx = $urandom_range(0, 13);
            if (idx == 13) a = $urandom_range(0, BASE - 1);
            else a = BASE + 32'(idx * 4) + $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) do_write(a, $urandom, 4'($urandom_range(0, 15)));
            else do_read(a, $urandom_range(0, 2));
        end

        // Reset in W_EXEC aborts the write with no response
        awaddr = BASE + 32'hC; awvalid = 1'b1; wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
        for (int i = 0; i < NRW; i++) rw_m[i] = '0;
        check("rstx_bvalid", bvalid, 1'b0);
        check("rstx_readies", {awready, wready, arready}, 3'b111);
        check("rstx_rw_q", rw_q, rw_flat());
        step();
        check("rstx_no_resp", {bvalid, rw_wr_pulse}, 5'b0);
        check("rstx_rw_q_after", rw_q, 128'h0);
        k = kind_of(BASE + 32'hC, idx);
        check("rstx_kind", k, 0);
        do_read(BASE + 32'hC, 0);
        model_write(0, 3, 32'h1111_2222, 4'hF, pexp);
        do_write(BASE + 32'hC, 32'h1111_2222, 4'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_lite_regbank.md
# axi_lite_regbank

Parametrised AXI4-Lite slave register bank, the next generation of the PS/PL control regfile. It provides NUM_RW host-writable control registers and NUM_RO host-readable status registers at a configurable base address. Host accesses use a single-outstanding AXI4-Lite port. It adds per-register write/read strobes and SLVERR/DECERR error responses. It sits between the PS/host AXI interconnect and the PL frame-buffer/DMA control logic.

## Interface
Parameters:
- ADDR_BITS, 32, AXI address width
- DATA_BITS, 32, register/data width; 32 or 64 only
- NUM_RW, 4, number of read/write control registers (1..64)
- NUM_RO, 8, number of read-only status registers (0..64)
- BASE_ADDR, 32'h40, byte address of register index 0; must be DATA_BYTES-aligned

Ports:
- s_axi_aclk  in  1  single clock
- s_axi_aresetn  in  1  reset, synchronous, active-low
- s_axi_awaddr/awvalid/awready, s_axi_wdata/wstrb/wvalid/wready, s_axi_bresp/bvalid/bready, s_axi_araddr/arvalid/arready, s_axi_rdata/rresp/rvalid/rready: standard AXI4-Lite; widths ADDR_BITS, DATA_BITS, DATA_BITS/8, 2
- rw_q  out  NUM_RW*DATA_BITS  flat control register contents, register i at [i*DATA_BITS +: DATA_BITS]
- rw_wr_pulse  out  NUM_RW  one-cycle strobe, bit i high in the cycle after register i is updated
- ro_d  in  NUM_RO*DATA_BITS  flat status inputs, same packing as rw_q
- ro_rd_pulse  out  NUM_RO  one-cycle strobe when status register i is returned on R (for clear-on-read logic)

## Operation
- Address decode: word index idx = (addr − BASE_ADDR) >> log2(DATA_BYTES). Low address bits are ignored.
  - idx < NUM_RW → RW register.
  - NUM_RW ≤ idx < NUM_RW+NUM_RO → RO register (RO index idx−NUM_RW).
  - addr < BASE_ADDR or idx beyond the RO range → unmapped.
- Write FSM states:
  - W_IDLE: awready and wready high independently. Each channel captures its address or data/strobe once and drops its ready. When both are captured, go to W_EXEC.
  - W_EXEC, one cycle: if RW, update byte lanes where wstrb=1 and set bresp OKAY. If RO, no update, bresp SLVERR (2'b10). If unmapped, no update, bresp DECERR (2'b11). Then go to W_RESP.
  - W_RESP: bvalid high until bready, then W_IDLE with awready=wready=1.
- Read FSM states:
  - R_IDLE: arready=1. On arvalid, register rdata/rresp from decode of araddr and go to R_DATA.
  - R_DATA: rvalid high, rdata/rresp held stable until rready, then R_IDLE.
  - Read data: rw_q or ro_d value for mapped addresses. Unmapped returns rdata=0 and rresp DECERR.
- ro_rd_pulse[i] asserts in the cycle the R handshake completes for status register i.
- Read and write FSMs run independently. A read accepted in the same cycle a W_EXEC updates that register returns the pre-update value.

## Timing
- Reset values: awready=1, wready=1, arready=1, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, all rw_q=0, rw_wr_pulse=0, ro_rd_pulse=0. FSMs return to W_IDLE/R_IDLE.
- Reset mid-transaction aborts it with no response; a pending write is not applied.
- Write, AW and W accepted on edge T: W_EXEC in cycle T+1, rw_q changes after edge T+1, rw_wr_pulse and bvalid high in cycle T+2.
- Write with AW and W on different edges: timing is counted from the later of the two.
- Read: AR accepted on edge T, rvalid high in T+1 with ro_d sampled at edge T. Back-to-back reads take a minimum of 2 cycles each.
- At most one outstanding write and one outstanding read.

## Configuration
- AXIL_REGBANK_ERR_RESP_EN:
  - Defined: SLVERR/DECERR responses as above.
  - Undefined: bresp/rresp are always OKAY. Writes to RO or unmapped addresses are still silently dropped, and unmapped reads still return 0.

## Structure
- Package axil_regbank_pkg:
  - AXI response constants RESP_OKAY/RESP_SLVERR/RESP_DECERR.
  - Write FSM encoding (W_IDLE/W_EXEC/W_RESP) and read FSM encoding (R_IDLE/R_DATA).
  - Decode result type (HIT_RW/HIT_RO/MISS).
- One sub-module, axil_regbank_decode: combinational address → {hit type, index}. It is instantiated twice, once for the write address and once for the read address.

## Test plan
- Reset, then read BASE_ADDR+0x0 → rdata=0, rresp=OKAY. All readies are 1 after reset.
- Write 0xA5A5_1234 to BASE_ADDR+0x4 with wstrb=4'b0101, reg previously 0 → rw_q[1]=0x00A5_0034. rw_wr_pulse[1] one cycle. bvalid in cycle T+2.
- W accepted 3 cycles before AW, bready held low 5 cycles → single update, bvalid stays high until bready, awready/wready stay low until then.
- ro_d[2]=0xDEAD_BEEF (NUM_RW=4), read BASE_ADDR+0x18 → rdata=0xDEAD_BEEF, rresp OKAY, ro_rd_pulse[2] on R handshake.
- Write to BASE_ADDR+0x10 (RO) → SLVERR, rw_q unchanged. Read BASE_ADDR+0x100 → DECERR, rdata=0. Without the macro, both return OKAY.
- Assert s_axi_aresetn low in W_EXEC → no register update, bvalid=0, all readies 1 after release.
